// File: rtl/clkdiv_seq_ctrl.sv
// clkdiv_seq_ctrl: steps ClkDiv's B_n through a programmable (divisor, hold) table,
// counting divided-clock rises per entry. Optional wrap-around build: CLKDIV_SEQ_LOOP_EN.
module clkdiv_seq_ctrl #(
  parameter int CNT_BW  = 13,
  parameter int DEPTH   = 8,
  parameter int AW      = 3,
  parameter int HOLD_BW = 8,
  parameter int TO_BW   = 16
) (
  input  logic               in_clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [CNT_BW-1:0]  wr_div,
  input  logic [HOLD_BW-1:0] wr_hold,
  input  logic [AW:0]        num_steps,
  input  logic               start,
  input  logic               abort,
`ifdef CLKDIV_SEQ_LOOP_EN
  input  logic               loop_en,
`endif
  input  logic               div_clk,
  output logic [CNT_BW-1:0]  B_n,
  output logic [AW-1:0]      step_idx,
  output logic               busy,
  output logic               done,
  output logic               timeout_err
);

  // state  | meaning
  // IDLE   | waiting for start; table writable
  // SETTLE | B_n just changed; next rise is discarded (possibly partial period)
  // RUN    | counting rises against the active entry's hold
  // FIN    | one-cycle done pulse, then back to IDLE
  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_FIN} state_t;

  localparam logic [AW:0]        DEPTH_W  = (AW+1)'(DEPTH);
  localparam logic [AW:0]        STEP_ONE = (AW+1)'(1);
  localparam logic [AW-1:0]      IDX_ONE  = AW'(1);
  localparam logic [CNT_BW-1:0]  DIV_ONE  = CNT_BW'(1);
  localparam logic [HOLD_BW-1:0] HOLD_ONE = HOLD_BW'(1);
  localparam logic [TO_BW-1:0]   WD_ONE   = TO_BW'(1);
  localparam logic [TO_BW-1:0]   WD_MAX   = '1;

  state_t state, state_nxt;

  logic [CNT_BW-1:0]  div_tab  [DEPTH];
  logic [HOLD_BW-1:0] hold_tab [DEPTH];
  logic               prev_div_clk;
  logic [HOLD_BW-1:0] hold_cnt;
  logic [TO_BW-1:0]   wd_cnt;
  logic [AW:0]        num_lat;
  logic               loop_mode;

  logic               rise;
  logic               wr_ok;
  logic               start_ok;
  logic               last_step;
  logic [AW-1:0]      step_nxt;
  logic [HOLD_BW-1:0] hold_inc;
  logic               hold_hit;
  logic [TO_BW-1:0]   wd_inc;
  logic               wd_expire;
  logic [CNT_BW-1:0]  wr_div_c;
  logic [HOLD_BW-1:0] wr_hold_c;
  logic [CNT_BW-1:0]  start_div;

`ifdef CLKDIV_SEQ_LOOP_EN
  logic loop_lat;
  assign loop_mode = loop_lat;
`else
  assign loop_mode = 1'b0;
`endif

  assign rise      = div_clk & ~prev_div_clk;
  assign wr_ok     = wr_en && (state == S_IDLE) && ({1'b0, wr_addr} < DEPTH_W);
  assign start_ok  = start && (state == S_IDLE) && (num_steps != '0) && (num_steps <= DEPTH_W);
  assign last_step = ({1'b0, step_idx} == (num_lat - STEP_ONE));
  assign step_nxt  = step_idx + IDX_ONE;
  assign hold_inc  = (hold_cnt == '1) ? hold_cnt : hold_cnt + HOLD_ONE;
  assign hold_hit  = (hold_inc == hold_tab[step_idx]);
  assign wd_inc    = (wd_cnt == WD_MAX) ? wd_cnt : wd_cnt + WD_ONE;
  assign wd_expire = (wd_inc == WD_MAX);
  assign wr_div_c  = (wr_div == '0) ? DIV_ONE : wr_div;
  assign wr_hold_c = (wr_hold == '0) ? HOLD_ONE : wr_hold;
  // A same-cycle write to entry 0 must be seen by the starting sequence.
  assign start_div = (wr_ok && (wr_addr == '0)) ? wr_div_c : div_tab[0];

  always_ff @(posedge in_clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok) state_nxt = S_SETTLE;
      S_SETTLE: begin
        if (abort)          state_nxt = S_IDLE;
        else if (rise)      state_nxt = S_RUN;
        else if (wd_expire) state_nxt = S_IDLE;
      end
      S_RUN: begin
        if (abort) state_nxt = S_IDLE;
        else if (rise) begin
          if (hold_hit) begin
            if (!last_step || loop_mode) state_nxt = S_SETTLE;
            else                         state_nxt = S_FIN;
          end
        end else if (wd_expire) state_nxt = S_IDLE;
      end
      S_FIN:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done = (state == S_FIN);
  end

  always_ff @(posedge in_clk) begin
    if (rst) begin
      prev_div_clk <= 1'b0;
      B_n          <= DIV_ONE;
      step_idx     <= '0;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      hold_cnt     <= '0;
      wd_cnt       <= '0;
      num_lat      <= '0;
`ifdef CLKDIV_SEQ_LOOP_EN
      loop_lat     <= 1'b0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
        div_tab[i]  <= DIV_ONE;
        hold_tab[i] <= HOLD_ONE;
      end
    end else begin
      prev_div_clk <= div_clk;
      busy         <= (state_nxt != S_IDLE);
      if (wr_ok) begin
        div_tab[wr_addr]  <= wr_div_c;
        hold_tab[wr_addr] <= wr_hold_c;
      end
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            num_lat     <= num_steps;
            step_idx    <= '0;
            B_n         <= start_div;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
            hold_cnt    <= '0;
`ifdef CLKDIV_SEQ_LOOP_EN
            loop_lat    <= loop_en;
`endif
          end
        end
        S_SETTLE, S_RUN: begin
          if (!abort) begin
            if (rise) begin
              wd_cnt <= '0;
              if (state == S_SETTLE) begin
                hold_cnt <= '0;
              end else begin
                hold_cnt <= hold_inc;
                if (hold_hit && !last_step) begin
                  step_idx <= step_nxt;
                  B_n      <= div_tab[step_nxt];
                end else if (hold_hit && loop_mode) begin
                  step_idx <= '0;
                  B_n      <= div_tab[0];
                end
              end
            end else begin
              wd_cnt <= wd_inc;
              if (wd_expire) timeout_err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
